mem_port_arbiter: RTL and testbench

- Shares one slow_memory-style port (128-bit line, address [31:4], level-held read/write until mem_ready) between the I-cache and D-cache miss paths inside CHIP.
- Lets the L2Cache and unified-memory configurations run with a single backing memory.
- Arbitrates, forwards the granted request, captures returning data and pulses the winner's ready.
- Counts stall cycles and flags a stuck transaction.

---
 rtl/mem_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one line-wide slow-memory port between the I-cache and D-cache miss paths.
// Arbitrates, forwards the granted request, captures read data and pulses the winner's ready.
//
// state  | meaning
// IDLE   | no memory request, sampling both ports
// GNT_I  | I-side request forwarded to memory
// GNT_D  | D-side request forwarded to memory
// DONE_I | one-cycle ready pulse to I, captured line on mem_rdata_I
// DONE_D | one-cycle ready pulse to D, captured line on mem_rdata_D
module mem_port_arbiter #(
  parameter int PRIO_MODE   = 0,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mem_read_I,
  input  logic         mem_write_I,
  input  logic [27:0]  mem_addr_I,
  input  logic [127:0] mem_wdata_I,
  output logic [127:0] mem_rdata_I,
  output logic         mem_ready_I,
  input  logic         mem_read_D,
  input  logic         mem_write_D,
  input  logic [27:0]  mem_addr_D,
  input  logic [127:0] mem_wdata_D,
  output logic [127:0] mem_rdata_D,
  output logic         mem_ready_D,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready,
  output logic         grant_D,
  output logic         timeout_err,
  output logic [15:0]  stall_cnt
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GNT_I  = 3'd1,
    GNT_D  = 3'd2,
    DONE_I = 3'd3,
    DONE_D = 3'd4
  } state_t;

  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYC);

  state_t      state;
  logic        last_d;
  logic [15:0] to_cnt;
  logic        req_i;
  logic        req_d;
  logic        pick_d;
  logic        waiting;

  assign req_i = mem_read_I | mem_write_I;
  assign req_d = mem_read_D | mem_write_D;

  // On contention, fixed priority always favours D; round-robin favours the side not served last.
  assign pick_d = req_d & (~req_i | (PRIO_MODE != 0) | ~last_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_d      <= 1'b0;
      to_cnt      <= 16'd0;
      timeout_err <= 1'b0;
      mem_rdata_I <= 128'd0;
      mem_rdata_D <= 128'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_i | req_d) begin
            state  <= pick_d ? GNT_D : GNT_I;
            to_cnt <= 16'd0;
          end
        end
        GNT_I, GNT_D: begin
          if (mem_ready) begin
            if (state == GNT_D) begin
              mem_rdata_D <= mem_rdata;
              last_d      <= 1'b1;
              state       <= DONE_D;
            end else begin
              mem_rdata_I <= mem_rdata;
              last_d      <= 1'b0;
              state       <= DONE_I;
            end
          end else if (to_cnt != TO_LIMIT) begin
            // Flag only; the transaction keeps waiting for the memory.
            to_cnt <= to_cnt + 16'd1;
            if (to_cnt + 16'd1 == TO_LIMIT) timeout_err <= 1'b1;
          end
        end
        DONE_I, DONE_D: state <= IDLE;
        default:        state <= IDLE;
      endcase
    end
  end

  assign waiting = ((state == GNT_I || state == DONE_I) && req_d) ||
                   ((state == GNT_D || state == DONE_D) && req_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 16'd0;
    end else if (waiting && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign mem_ready_I = (state == DONE_I);
  assign mem_ready_D = (state == DONE_D);
  assign grant_D     = (state == GNT_D);

  // Request path is combinational from the owner so the memory sees it in the first grant cycle.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = 28'd0;
    mem_wdata = 128'd0;
    case (state)
      GNT_I: begin
        mem_write = mem_write_I;
        mem_read  = mem_read_I & ~mem_write_I;
        mem_addr  = mem_addr_I;
        mem_wdata = mem_wdata_I;
      end
      GNT_D: begin
        mem_write = mem_write_D;
        mem_read  = mem_read_D & ~mem_write_D;
        mem_addr  = mem_addr_D;
        mem_wdata = mem_wdata_D;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: round-robin and fixed-priority instances share requester stimulus,
// each with its own memory responder; a transaction-level model is compared every cycle.
module tb_mem_port_arbiter;
  localparam int TO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n   = 1'b0;
  logic         rd_i    = 1'b0, wr_i = 1'b0, rd_d = 1'b0, wr_d = 1'b0;
  logic [27:0]  addr_i  = '0, addr_d = '0;
  logic [127:0] wdata_i = '0, wdata_d = '0;
  logic [127:0] mem_rdata = '0;
  logic         mem_ready [2];

  logic [127:0] rdata_i_o [2], rdata_d_o [2], wdata_o [2];
  logic         rdy_i_o [2], rdy_d_o [2], mrd_o [2], mwr_o [2], gnt_d_o [2], terr_o [2];
  logic [27:0]  addr_o [2];
  logic [15:0]  stall_o [2];

  mem_port_arbiter #(.PRIO_MODE(0), .TIMEOUT_CYC(TO)) u0 (
    .clk(clk), .rst_n(rst_n),
    .mem_read_I(rd_i), .mem_write_I(wr_i), .mem_addr_I(addr_i), .mem_wdata_I(wdata_i),
    .mem_rdata_I(rdata_i_o[0]), .mem_ready_I(rdy_i_o[0]),
    .mem_read_D(rd_d), .mem_write_D(wr_d), .mem_addr_D(addr_d), .mem_wdata_D(wdata_d),
    .mem_rdata_D(rdata_d_o[0]), .mem_ready_D(rdy_d_o[0]),
    .mem_read(mrd_o[0]), .mem_write(mwr_o[0]), .mem_addr(addr_o[0]), .mem_wdata(wdata_o[0]),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready[0]),
    .grant_D(gnt_d_o[0]), .timeout_err(terr_o[0]), .stall_cnt(stall_o[0])
  );

  mem_port_arbiter #(.PRIO_MODE(1), .TIMEOUT_CYC(TO)) u1 (
    .clk(clk), .rst_n(rst_n),
    .mem_read_I(rd_i), .mem_write_I(wr_i), .mem_addr_I(addr_i), .mem_wdata_I(wdata_i),
    .mem_rdata_I(rdata_i_o[1]), .mem_ready_I(rdy_i_o[1]),
    .mem_read_D(rd_d), .mem_write_D(wr_d), .mem_addr_D(addr_d), .mem_wdata_D(wdata_d),
    .mem_rdata_D(rdata_d_o[1]), .mem_ready_D(rdy_d_o[1]),
    .mem_read(mrd_o[1]), .mem_write(mwr_o[1]), .mem_addr(addr_o[1]), .mem_wdata(wdata_o[1]),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready[1]),
    .grant_D(gnt_d_o[1]), .timeout_err(terr_o[1]), .stall_cnt(stall_o[1])
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model: owner -1 = nobody, 0 = I, 1 = D; fin marks the completion cycle.
  int           own [2];
  bit           fin [2];
  bit           last_d [2];
  int           tcnt [2];
  bit           terr [2];
  int           stall [2];
  logic [127:0] m_rd_i [2], m_rd_d [2];
  int           act [2];
  int           mem_lat = 4;
  logic [127:0] rdata_pat = '0;
  bit           vary = 1'b0;
  int           cyc = 0;

  function automatic void model_reset(input int i);
    own[i] = -1; fin[i] = 1'b0; last_d[i] = 1'b0; tcnt[i] = 0;
    terr[i] = 1'b0; stall[i] = 0; m_rd_i[i] = '0; m_rd_d[i] = '0;
  endfunction

  task automatic compare(input int i);
    bit g, od;
    logic erd, ewr;
    logic [27:0] ea;
    logic [127:0] ew;
    g   = (own[i] >= 0) && !fin[i];
    od  = (own[i] == 1);
    erd = g && (od ? (rd_d && !wr_d) : (rd_i && !wr_i));
    ewr = g && (od ? wr_d : wr_i);
    ea  = g ? (od ? addr_d : addr_i) : 28'd0;
    ew  = g ? (od ? wdata_d : wdata_i) : 128'd0;
    check($sformatf("u%0d.mem_read", i),    128'(mrd_o[i]),   128'(erd));
    check($sformatf("u%0d.mem_write", i),   128'(mwr_o[i]),   128'(ewr));
    check($sformatf("u%0d.mem_addr", i),    128'(addr_o[i]),  128'(ea));
    check($sformatf("u%0d.mem_wdata", i),   wdata_o[i],       ew);
    check($sformatf("u%0d.ready_I", i),     128'(rdy_i_o[i]), 128'(fin[i] && own[i] == 0));
    check($sformatf("u%0d.ready_D", i),     128'(rdy_d_o[i]), 128'(fin[i] && own[i] == 1));
    check($sformatf("u%0d.grant_D", i),     128'(gnt_d_o[i]), 128'(g && od));
    check($sformatf("u%0d.rdata_I", i),     rdata_i_o[i],     m_rd_i[i]);
    check($sformatf("u%0d.rdata_D", i),     rdata_d_o[i],     m_rd_d[i]);
    check($sformatf("u%0d.timeout_err", i), 128'(terr_o[i]),  128'(terr[i]));
    check($sformatf("u%0d.stall_cnt", i),   128'(stall_o[i]), 128'(stall[i]));
  endtask

  function automatic void advance(input int i);
    bit ri, rq;
    ri = rd_i | wr_i;
    rq = rd_d | wr_d;
    if (own[i] >= 0 && ((own[i] == 0) ? rq : ri))
      stall[i] = (stall[i] == 65535) ? 65535 : stall[i] + 1;
    if (own[i] < 0) begin
      if (ri || rq) begin
        if (ri && rq) own[i] = (i == 1 || !last_d[i]) ? 1 : 0;
        else          own[i] = rq ? 1 : 0;
        fin[i] = 1'b0;
        tcnt[i] = 0;
      end
    end else if (!fin[i]) begin
      if (mem_ready[i]) begin
        if (own[i] == 0) m_rd_i[i] = mem_rdata;
        else             m_rd_d[i] = mem_rdata;
        last_d[i] = (own[i] == 1);
        fin[i] = 1'b1;
      end else if (tcnt[i] < TO) begin
        tcnt[i]++;
        if (tcnt[i] == TO) terr[i] = 1'b1;
      end
    end else begin
      own[i] = -1;
      fin[i] = 1'b0;
    end
  endfunction

  initial begin
    for (int i = 0; i < 2; i++) begin
      model_reset(i);
      mem_ready[i] = 1'b0;
      act[i] = 0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        for (int i = 0; i < 2; i++) begin
          model_reset(i);
          mem_ready[i] = 1'b0;
          act[i] = 0;
        end
      end
      for (int i = 0; i < 2; i++) compare(i);
      if (rst_n) begin
        mem_rdata = vary ? ({4{32'(cyc)}} ^ rdata_pat) : rdata_pat;
        for (int i = 0; i < 2; i++) begin
          if (mrd_o[i] | mwr_o[i]) act[i]++;
          else act[i] = 0;
          mem_ready[i] = (mem_lat != 0) && (act[i] == mem_lat);
          advance(i);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  int n, d1, i1, k, pulses, ipulses;
  bit order [4];

  initial begin
    rdata_pat = {4{32'hA5A5A5A5}};
    mem_lat = 4;
    repeat (3) @(posedge clk);
    #1;
    check("rst.mem_read", 128'(mrd_o[0] | mwr_o[0]), 128'd0);
    check("rst.ready", 128'(rdy_i_o[0] | rdy_d_o[0]), 128'd0);
    check("rst.stall", 128'(stall_o[0]), 128'd0);
    rst_n = 1'b1;

    // Lone I read, memory latency 4
    @(posedge clk); #1;
    rd_i = 1'b1; addr_i = 28'h0000ABC;
    @(negedge clk);
    check("t1.mem_read_c0", 128'(mrd_o[0]), 128'd0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check("t1.mem_read_req", 128'(mrd_o[0]), 128'd1);
      check("t1.ready_early", 128'(rdy_i_o[0]), 128'd0);
    end
    @(negedge clk);
    check("t1.ready_c5", 128'(rdy_i_o[0]), 128'd1);
    check("t1.rdata_c5", rdata_i_o[0], {4{32'hA5A5A5A5}});
    check("t1.mem_read_c5", 128'(mrd_o[0]), 128'd0);
    @(posedge clk); #1;
    rd_i = 1'b0;

    // Continuous contention
    mem_lat = 3; vary = 1'b1; rdata_pat = 128'h0F0F_0000_0000_0000_0000_0000_0000_0000;
    @(posedge clk); #1;
    rd_i = 1'b1; rd_d = 1'b1; addr_i = 28'h0000100; addr_d = 28'h0000200;
    n = 0; d1 = 0; i1 = 0; k = 0;
    while (n < 4 && k < 60) begin
      @(negedge clk);
      k++;
      if (rdy_d_o[0] | rdy_i_o[0]) begin
        order[n] = rdy_d_o[0];
        n++;
      end
      if (rdy_d_o[1]) d1++;
      if (rdy_i_o[1]) i1++;
    end
    check("t3.rr_count", 128'(n), 128'd4);
    check("t3.rr_order0", 128'(order[0]), 128'd1);
    check("t3.rr_order1", 128'(order[1]), 128'd0);
    check("t3.rr_order2", 128'(order[2]), 128'd1);
    check("t3.rr_order3", 128'(order[3]), 128'd0);
    check("t3.prio_d_served", 128'(d1), 128'd4);
    check("t3.prio_i_served", 128'(i1), 128'd0);
    @(posedge clk); #1;
    rd_d = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!rdy_i_o[1] && k < 20);
    check("t3.prio_i_wait", 128'(k), 128'd5);
    @(posedge clk); #1;
    rd_i = 1'b0;
    @(negedge clk);
    check("t3.stall_rr", 128'(stall_o[0]), 128'd16);
    check("t3.stall_prio", 128'(stall_o[1]), 128'd16);

    // Lone D write
    mem_lat = 2;
    @(posedge clk); #1;
    wr_d = 1'b1; addr_d = 28'h0000010; wdata_d = 128'h1234;
    @(negedge clk);
    @(negedge clk);
    check("t2.mem_write", 128'(mwr_o[0]), 128'd1);
    check("t2.mem_read", 128'(mrd_o[0]), 128'd0);
    check("t2.mem_addr", 128'(addr_o[0]), 128'h0000010);
    check("t2.mem_wdata", wdata_o[0], 128'h1234);
    pulses = 0; ipulses = 0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      pulses += int'(rdy_d_o[0]);
      ipulses += int'(rdy_i_o[0]);
      if (rdy_d_o[0]) begin
        @(posedge clk); #1;
        wr_d = 1'b0;
      end
    end
    check("t2.ready_D_pulses", 128'(pulses), 128'd1);
    check("t2.ready_I_pulses", 128'(ipulses), 128'd0);

    // D read+write together, then reset mid-grant
    mem_lat = 6;
    @(posedge clk); #1;
    rd_d = 1'b1; wr_d = 1'b1; addr_d = 28'h0000020; wdata_d = 128'hBEEF;
    @(negedge clk);
    @(negedge clk);
    check("t5.rw_write", 128'(mwr_o[0]), 128'd1);
    check("t5.rw_read", 128'(mrd_o[0]), 128'd0);
    check("t5.grant_D", 128'(gnt_d_o[0]), 128'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5.rst_req", 128'(mrd_o[0] | mwr_o[0]), 128'd0);
    check("t5.rst_addr", 128'(addr_o[0]), 128'd0);
    check("t5.rst_wdata", wdata_o[0], 128'd0);
    check("t5.rst_grant", 128'(gnt_d_o[0]), 128'd0);
    check("t5.rst_stall", 128'(stall_o[0]), 128'd0);
    check("t5.rst_rdata_I", rdata_i_o[0], 128'd0);
    rd_d = 1'b0; wr_d = 1'b0;
    @(negedge clk); #2;
    rst_n = 1'b1;
    mem_lat = 1;
    @(posedge clk); #1;
    rd_i = 1'b1; addr_i = 28'h0000333;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!rdy_i_o[0] && k < 10);
    check("t5.i_after_rst_lat", 128'(k), 128'd3);
    @(posedge clk); #1;
    rd_i = 1'b0;

    // Timeout with a memory that stalls
    mem_lat = 0;
    @(posedge clk); #1;
    rd_i = 1'b1; addr_i = 28'h0000444;
    for (int c = 0; c <= 9; c++) begin
      @(negedge clk);
      if (c == 8) check("t6.err_before", 128'(terr_o[0]), 128'd0);
      if (c == 9) begin
        check("t6.err_set", 128'(terr_o[0]), 128'd1);
        check("t6.read_held", 128'(mrd_o[0]), 128'd1);
      end
    end
    mem_lat = 12;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!rdy_i_o[0] && k < 20);
    check("t6.completes", 128'(rdy_i_o[0]), 128'd1);
    check("t6.err_sticky", 128'(terr_o[0]), 128'd1);
    @(posedge clk); #1;
    rd_i = 1'b0;
    repeat (3) @(negedge clk);
    check("t6.err_sticky_idle", 128'(terr_o[1]), 128'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
